mem_port_arbiter: RTL

- Sequences a single-ported, 16-bit-wide program/data memory and shares it between two requesters: the fetch stage (32-bit read) and the memory stage (32-bit load/store).
- Each 32-bit access is performed as two 16-bit beats. The low half sits at word address A; the high half sits at A+1.
- The block sits between the core pipeline and the RAM array and drives the RAM's address, write-enable and write-data.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares a single-ported 16-bit RAM between the fetch stage (32-bit reads)
// and the memory stage (32-bit loads/stores). Every 32-bit access is split
// into two beats: the low half at word address A, then the high half at
// (A+1) mod 2**ADDR_W.
//
// FSM: IDLE -> LO -> HI -> DONE -> IDLE. All outputs are registered.
//
// Arbitration happens in IDLE only:
//   - Data wins a tie.
//   - After STARVE_MAX consecutive data grants made while fetch was waiting,
//     fetch wins once.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   if_req/if_addr      fetch request and word address
//   if_rdata/if_done    fetch result {RAM[A+1],RAM[A]} with one-cycle done
//   dm_req/dm_we        data request, 1 = store
//   dm_addr/dm_wdata    data word address and store data (sampled at grant)
//   dm_rdata/dm_done    load result (0 for stores) with one-cycle done
//   mem_addr/mem_we     RAM address and write strobe
//   mem_wdata           RAM write data (0 whenever mem_we is low)
//   mem_rdata           RAM combinational read data for mem_addr
//   busy                high whenever the FSM is not in IDLE
//
// Optional build macro ARB_STATS_EN adds:
//   conflict_cnt[15:0]  IDLE cycles with both requests high (saturating)
//   starve_evt[7:0]     forced fetch grants (saturating)
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
`ifdef ARB_STATS_EN
    output logic [15:0]       conflict_cnt,
    output logic [7:0]        starve_evt,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_reg;
    logic              owner_dm_reg;   // 1 = data port owns the access
    logic              we_reg;
    logic [ADDR_W-1:0] a_reg;
    logic [15:0]       wdata_hi_reg;   // low half goes straight to mem_wdata at grant
    logic [15:0]       result_lo_reg;
    logic [3:0]        starve_cnt_reg;

    logic              grant_dm;
    logic              grant_if;
    logic              grant_store;
    logic [ADDR_W-1:0] grant_addr;

    // Upper address bits are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

    always_comb begin
        grant_dm    = dm_req && (!if_req || (starve_cnt_reg != STARVE_LIM));
        grant_if    = if_req && !grant_dm;
        grant_store = grant_dm && dm_we;
        grant_addr  = grant_dm ? dm_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_dm_reg   <= 1'b0;
            we_reg         <= 1'b0;
            a_reg          <= '0;
            wdata_hi_reg   <= '0;
            result_lo_reg  <= '0;
            starve_cnt_reg <= '0;
            if_rdata       <= '0;
            if_done        <= 1'b0;
            dm_rdata       <= '0;
            dm_done        <= 1'b0;
            mem_addr       <= '0;
            mem_we         <= 1'b0;
            mem_wdata      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_dm || grant_if) begin
                        state_reg    <= LO;
                        owner_dm_reg <= grant_dm;
                        we_reg       <= grant_store;
                        a_reg        <= grant_addr;
                        wdata_hi_reg <= grant_store ? dm_wdata[31:16] : 16'h0000;
                        // Present the low beat during LO.
                        mem_addr     <= grant_addr;
                        mem_we       <= grant_store;
                        mem_wdata    <= grant_store ? dm_wdata[15:0] : 16'h0000;
                    end
                    if (grant_if) begin
                        starve_cnt_reg <= '0;
                    end else if (grant_dm && if_req && (starve_cnt_reg != STARVE_LIM)) begin
                        starve_cnt_reg <= starve_cnt_reg + 4'd1;
                    end
                end
                LO: begin
                    state_reg <= HI;
                    // Natural ADDR_W-bit wrap: the top word is followed by word 0.
                    mem_addr  <= a_reg + ADDR_W'(1);
                    if (we_reg) begin
                        mem_wdata <= wdata_hi_reg;
                    end else begin
                        result_lo_reg <= mem_rdata;
                    end
                end
                HI: begin
                    state_reg <= DONE;
                    mem_we    <= 1'b0;
                    mem_wdata <= 16'h0000;
                    if (owner_dm_reg) begin
                        dm_done  <= 1'b1;
                        dm_rdata <= we_reg ? 32'h0 : {mem_rdata, result_lo_reg};
                    end else begin
                        if_done  <= 1'b1;
                        if_rdata <= {mem_rdata, result_lo_reg};
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    if_done   <= 1'b0;
                    dm_done   <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
            starve_evt   <= '0;
        end else if (state_reg == IDLE && if_req && dm_req) begin
            if (conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            // Fetch winning a tie can only be the forced case.
            if (!grant_dm && starve_evt != 8'hFF) begin
                starve_evt <= starve_evt + 8'd1;
            end
        end
    end
`endif

endmodule
